// File: rtl/ttl_pin_tester.sv
// Pin-level checker for 14-pin TTL chip models (7408/7432/7486/7404/7410/7474).
// Define TTL_TESTER_STOP_ON_FAIL_EN to end a test at the first mismatching vector.
module ttl_pin_tester #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  chip_sel,
    output logic [11:0] drive,
    output logic [11:0] drive_oe,
    input  logic [11:0] sense,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        bad_sel,
    output logic [7:0]  err_count,
    output logic [8:0]  first_fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_sel;
    logic        r_bad;
    logic [8:0]  r_v;
    logic [3:0]  r_cnt;
    logic [11:0] r_drive;
    logic [11:0] r_oe;
    logic [7:0]  r_err;
    logic [8:0]  r_first;

    logic [11:0] w_vec_drive;
    logic [11:0] w_vec_oe;
    logic        w_last;
    logic [3:0]  w_ff;
    logic        w_q;
    logic [11:0] w_expect;
    logic        w_mismatch;

    // Vector index to pin drive; 7474 steps are {CLRn, PREn, CLK, D}, mirrored on both flip-flops.
    always_comb begin
        w_vec_drive = '0;
        w_vec_oe    = '0;
        w_last      = 1'b1;
        w_ff        = 4'b0000;
        case (r_sel)
            3'd0, 3'd1, 3'd2: begin
                w_vec_oe        = 12'hD9B;
                w_vec_drive[0]  = r_v[0];
                w_vec_drive[1]  = r_v[1];
                w_vec_drive[3]  = r_v[2];
                w_vec_drive[4]  = r_v[3];
                w_vec_drive[7]  = r_v[4];
                w_vec_drive[8]  = r_v[5];
                w_vec_drive[10] = r_v[6];
                w_vec_drive[11] = r_v[7];
                w_last          = (r_v == 9'd255);
            end
            3'd3: begin
                w_vec_oe        = 12'hA95;
                w_vec_drive[0]  = r_v[0];
                w_vec_drive[2]  = r_v[1];
                w_vec_drive[4]  = r_v[2];
                w_vec_drive[7]  = r_v[3];
                w_vec_drive[9]  = r_v[4];
                w_vec_drive[11] = r_v[5];
                w_last          = (r_v == 9'd63);
            end
            3'd4: begin
                w_vec_oe         = 12'hB9F;
                w_vec_drive[4:0] = r_v[4:0];
                w_vec_drive[7]   = r_v[5];
                w_vec_drive[8]   = r_v[6];
                w_vec_drive[9]   = r_v[7];
                w_vec_drive[11]  = r_v[8];
                w_last           = (r_v == 9'd511);
            end
            3'd5: begin
                w_vec_oe = 12'hF0F;
                case (r_v[2:0])
                    3'd0:    w_ff = 4'b0100;
                    3'd1:    w_ff = 4'b1000;
                    3'd2:    w_ff = 4'b1100;
                    3'd3:    w_ff = 4'b1110;
                    3'd4:    w_ff = 4'b1101;
                    3'd5:    w_ff = 4'b1111;
                    3'd6:    w_ff = 4'b1110;
                    default: w_ff = 4'b1100;
                endcase
                w_vec_drive[0]  = w_ff[3];
                w_vec_drive[11] = w_ff[3];
                w_vec_drive[3]  = w_ff[2];
                w_vec_drive[8]  = w_ff[2];
                w_vec_drive[2]  = w_ff[1];
                w_vec_drive[9]  = w_ff[1];
                w_vec_drive[1]  = w_ff[0];
                w_vec_drive[10] = w_ff[0];
                w_last          = (r_v == 9'd7);
            end
            default: ;
        endcase
    end

    // Golden outputs computed from the pins actually being driven.
    always_comb begin
        w_expect = '0;
        w_q      = 1'b0;
        case (r_sel)
            3'd0: begin
                w_expect[2] = r_drive[0] & r_drive[1];
                w_expect[5] = r_drive[3] & r_drive[4];
                w_expect[6] = r_drive[7] & r_drive[8];
                w_expect[9] = r_drive[10] & r_drive[11];
            end
            3'd1: begin
                w_expect[2] = r_drive[0] | r_drive[1];
                w_expect[5] = r_drive[3] | r_drive[4];
                w_expect[6] = r_drive[7] | r_drive[8];
                w_expect[9] = r_drive[10] | r_drive[11];
            end
            3'd2: begin
                w_expect[2] = r_drive[0] ^ r_drive[1];
                w_expect[5] = r_drive[3] ^ r_drive[4];
                w_expect[6] = r_drive[7] ^ r_drive[8];
                w_expect[9] = r_drive[10] ^ r_drive[11];
            end
            3'd3: begin
                w_expect[1]  = ~r_drive[0];
                w_expect[3]  = ~r_drive[2];
                w_expect[5]  = ~r_drive[4];
                w_expect[6]  = ~r_drive[7];
                w_expect[8]  = ~r_drive[9];
                w_expect[10] = ~r_drive[11];
            end
            3'd4: begin
                w_expect[10] = ~(r_drive[0] & r_drive[1] & r_drive[11]);
                w_expect[5]  = ~(r_drive[2] & r_drive[3] & r_drive[4]);
                w_expect[6]  = ~(r_drive[7] & r_drive[8] & r_drive[9]);
            end
            3'd5: begin
                w_q         = (r_v[2:0] == 3'd1) || (r_v[2:0] == 3'd2) || (r_v[2:0] >= 3'd5);
                w_expect[4] = w_q;
                w_expect[7] = w_q;
                w_expect[5] = ~w_q;
                w_expect[6] = ~w_q;
            end
            default: ;
        endcase
    end

    assign w_mismatch = |((sense ^ w_expect) & ~r_oe);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_next = (chip_sel > 3'd5) ? S_DONE : S_DRIVE;
            end
            S_DRIVE:  w_next = S_SETTLE;
            S_SETTLE: begin
                if (r_cnt == SETTLE_LAST) w_next = S_CHECK;
            end
            S_CHECK: begin
`ifdef TTL_TESTER_STOP_ON_FAIL_EN
                if (w_mismatch || w_last) w_next = S_DONE;
                else                      w_next = S_DRIVE;
`else
                if (w_last) w_next = S_DONE;
                else        w_next = S_DRIVE;
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel   <= '0;
            r_bad   <= 1'b0;
            r_v     <= '0;
            r_cnt   <= '0;
            r_drive <= '0;
            r_oe    <= '0;
            r_err   <= '0;
            r_first <= '1;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_sel   <= chip_sel;
                        r_bad   <= (chip_sel > 3'd5);
                        r_v     <= '0;
                        r_err   <= '0;
                        r_first <= '1;
                        r_drive <= '0;
                        r_oe    <= '0;
                    end
                end
                S_DRIVE: begin
                    r_drive <= w_vec_drive;
                    r_oe    <= w_vec_oe;
                    r_cnt   <= '0;
                end
                S_SETTLE: r_cnt <= r_cnt + 4'd1;
                S_CHECK: begin
                    // A zero count means no earlier failure; saturation never returns it to zero.
                    if (w_mismatch) begin
                        if (r_err != 8'hFF) r_err <= r_err + 8'd1;
                        if (r_err == '0)    r_first <= r_v;
                    end
                    if (w_next == S_DONE) begin
                        r_drive <= '0;
                        r_oe    <= '0;
                    end else begin
                        r_v <= r_v + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign drive      = r_drive;
    assign drive_oe   = r_oe;
    assign busy       = (r_state == S_DRIVE) || (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign done       = (r_state == S_DONE);
    assign pass       = done && !r_bad && (r_err == '0);
    assign bad_sel    = done && r_bad;
    assign err_count  = r_err;
    assign first_fail = r_first;

endmodule

// File: tb/tb_ttl_pin_tester.sv
// Bench for ttl_pin_tester: behavioural chip models with fault masks and a result scoreboard.
module tb_ttl_pin_tester;

    localparam int unsigned SET = 2;
    localparam int PER = SET + 2;
`ifdef TTL_TESTER_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  chip_sel;
    logic [11:0] drive;
    logic [11:0] drive_oe;
    logic [11:0] sense;
    logic        busy;
    logic        done;
    logic        pass;
    logic        bad_sel;
    logic [7:0]  err_count;
    logic [8:0]  first_fail;

    ttl_pin_tester #(.SETTLE(SET)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .chip_sel   (chip_sel),
        .drive      (drive),
        .drive_oe   (drive_oe),
        .sense      (sense),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .bad_sel    (bad_sel),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    always #5 clk = ~clk;

    // Chip under test: model_sel picks the plugged chip; st0/st1/inv plant pin faults.
    int          model_sel = 0;
    logic [11:0] st0 = '0;
    logic [11:0] st1 = '0;
    logic [11:0] inv = '0;
    logic [11:0] s_raw;
    logic        q1 = 1'b0, q2 = 1'b0, c1 = 1'b0, c2 = 1'b0;

    function automatic int bit_of(input int n);
        return (n <= 6) ? n - 1 : n - 2;
    endfunction

    function automatic logic pin(input logic [11:0] d, input int n);
        return d[bit_of(n)];
    endfunction

    always_comb begin
        s_raw = drive;
        case (model_sel)
            0: begin
                s_raw[bit_of(3)]  = pin(drive, 1) & pin(drive, 2);
                s_raw[bit_of(6)]  = pin(drive, 4) & pin(drive, 5);
                s_raw[bit_of(8)]  = pin(drive, 9) & pin(drive, 10);
                s_raw[bit_of(11)] = pin(drive, 12) & pin(drive, 13);
            end
            1: begin
                s_raw[bit_of(3)]  = pin(drive, 1) | pin(drive, 2);
                s_raw[bit_of(6)]  = pin(drive, 4) | pin(drive, 5);
                s_raw[bit_of(8)]  = pin(drive, 9) | pin(drive, 10);
                s_raw[bit_of(11)] = pin(drive, 12) | pin(drive, 13);
            end
            2: begin
                s_raw[bit_of(3)]  = pin(drive, 1) ^ pin(drive, 2);
                s_raw[bit_of(6)]  = pin(drive, 4) ^ pin(drive, 5);
                s_raw[bit_of(8)]  = pin(drive, 9) ^ pin(drive, 10);
                s_raw[bit_of(11)] = pin(drive, 12) ^ pin(drive, 13);
            end
            3: begin
                s_raw[bit_of(2)]  = ~pin(drive, 1);
                s_raw[bit_of(4)]  = ~pin(drive, 3);
                s_raw[bit_of(6)]  = ~pin(drive, 5);
                s_raw[bit_of(8)]  = ~pin(drive, 9);
                s_raw[bit_of(10)] = ~pin(drive, 11);
                s_raw[bit_of(12)] = ~pin(drive, 13);
            end
            4: begin
                s_raw[bit_of(12)] = ~(pin(drive, 1) & pin(drive, 2) & pin(drive, 13));
                s_raw[bit_of(6)]  = ~(pin(drive, 3) & pin(drive, 4) & pin(drive, 5));
                s_raw[bit_of(8)]  = ~(pin(drive, 9) & pin(drive, 10) & pin(drive, 11));
            end
            5: begin
                s_raw[bit_of(5)] = q1;
                s_raw[bit_of(6)] = ~q1;
                s_raw[bit_of(9)] = q2;
                s_raw[bit_of(8)] = ~q2;
            end
            default: ;
        endcase
        sense = ((s_raw & ~st0) | st1) ^ inv;
    end

    // 7474 model: async clear/preset, rising-edge capture of the CLK pin.
    always @(posedge clk) begin
        if (!pin(drive, 1))                       q1 <= 1'b0;
        else if (!pin(drive, 4))                  q1 <= 1'b1;
        else if (pin(drive, 3) && !c1)            q1 <= pin(drive, 2);
        c1 <= pin(drive, 3);
        if (!pin(drive, 13))                      q2 <= 1'b0;
        else if (!pin(drive, 10))                 q2 <= 1'b1;
        else if (pin(drive, 11) && !c2)           q2 <= pin(drive, 12);
        c2 <= pin(drive, 11);
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        string tag;
        int    cycles;
        logic  pass;
        logic  bad;
        int    err;
        int    first;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int nvec, input int err_full,
                            input int first_full, input logic bad);
        exp_t e;
        e.tag   = tag;
        e.bad   = bad;
        e.first = first_full;
        if (bad) begin
            e.err    = 0;
            e.cycles = 1;
        end else if (STOP && err_full > 0) begin
            e.err    = 1;
            e.cycles = (first_full + 1) * PER + 1;
        end else begin
            e.err    = (err_full > 255) ? 255 : err_full;
            e.cycles = nvec * PER + 1;
        end
        e.pass = !bad && (e.err == 0);
        sb.push_back(e);
    endtask

    task automatic start_test(input logic [2:0] sel);
        @(negedge clk);
        chip_sel = sel;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic finish_test(input int limit);
        exp_t e;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        check({e.tag, " done"},     32'(done),       32'd1);
        check({e.tag, " cycles"},   32'(cyc),        32'(e.cycles));
        check({e.tag, " pass"},     32'(pass),       32'(e.pass));
        check({e.tag, " bad_sel"},  32'(bad_sel),    32'(e.bad));
        check({e.tag, " err"},      32'(err_count),  32'(e.err));
        check({e.tag, " first"},    32'(first_fail), 32'(e.first));
        check({e.tag, " oe_rel"},   32'(drive_oe),   32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " busy"},  32'(busy),       32'd0);
        check({tag, " done"},  32'(done),       32'd0);
        check({tag, " pass"},  32'(pass),       32'd0);
        check({tag, " bad"},   32'(bad_sel),    32'd0);
        check({tag, " err"},   32'(err_count),  32'd0);
        check({tag, " first"}, 32'(first_fail), 32'h1FF);
        check({tag, " drive"}, 32'(drive),      32'd0);
        check({tag, " oe"},    32'(drive_oe),   32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        chip_sel = 3'd0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("start_in_rst busy", 32'(busy), 32'd0);
        check("start_in_rst done", 32'(done), 32'd0);

        model_sel = 0;
        push_exp("7408_good", 256, 0, 'h1FF, 1'b0);
        start_test(3'd0);
        check("7408 busy_c1", 32'(busy), 32'd1);
        step_to(3);
        check("7408 oe_v0", 32'(drive_oe), 32'hD9B);
        step_to(7);
        check("7408 drive_v1", 32'(drive), 32'h001);
        finish_test(2000);
        repeat (3) @(negedge clk);
        check("7408 done_held", 32'(done), 32'd1);

        model_sel = 3;
        st0       = 12'h100;
        push_exp("7404_p10_lo", 64, 32, 0, 1'b0);
        start_test(3'd3);
        finish_test(500);
        st0 = '0;

        model_sel = 5;
        push_exp("7474_good", 8, 0, 'h1FF, 1'b0);
        start_test(3'd5);
        finish_test(100);

        st1 = 12'h010;
        push_exp("7474_p05_hi", 8, 3, 0, 1'b0);
        start_test(3'd5);
        finish_test(100);
        st1 = '0;

        push_exp("sel7", 0, 0, 'h1FF, 1'b1);
        start_test(3'd7);
        finish_test(10);
        check("sel7 drive", 32'(drive), 32'd0);

        push_exp("sel6", 0, 0, 'h1FF, 1'b1);
        start_test(3'd6);
        finish_test(10);

        model_sel = 1;
        st0       = 12'h004;
        push_exp("7432_p03_lo", 256, 192, 1, 1'b0);
        start_test(3'd1);
        finish_test(2000);
        st0 = '0;

        model_sel = 2;
        push_exp("7486_good", 256, 0, 'h1FF, 1'b0);
        start_test(3'd2);
        finish_test(2000);

        model_sel = 4;
        inv       = 12'h460;
        push_exp("7410_sat", 512, 512, 0, 1'b0);
        start_test(3'd4);
        finish_test(3000);
        inv = '0;

        start_test(3'd4);
        step_to(399);
        check("7410 drive_v99", 32'(drive),    32'h183);
        check("7410 oe_v99",    32'(drive_oe), 32'hB9F);
        check("7410 busy_v99",  32'(busy),     32'd1);
        step_to(401);
        #2 rst = 1'b1;
        #1 check_reset_vals("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        push_exp("7410_rerun", 512, 0, 'h1FF, 1'b0);
        start_test(3'd4);
        finish_test(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
